rll_key_loader: RTL and testbench
=================================

# rll_key_loader

Serial key-delivery stage that sits directly upstream of the RLL-locked combinational netlists and drives their `keyIn_0_*` inputs. It accepts a key bit-serially over a valid/ready handshake and optionally checks a trailing CRC-8. Only a verified key is committed to the parallel key bus; a failed or aborted load leaves the previously committed key in place.

## Interface

Parameters:
- `KEY_W`, default 32: key width, equal to the number of `keyIn_0_*` inputs on the locked netlist.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `load_start` in 1: one-cycle request to begin a new load; also aborts a load in progress.
- `sdi` in 1: serial data bit, MSB first.
- `sdi_valid` in 1: `sdi` holds a valid bit this cycle.
- `sdi_ready` out 1: loader accepts a bit this cycle.
- `key_out` out KEY_W: committed key; bit i drives `keyIn_0_i`.
- `key_valid` out 1: `key_out` holds a committed, checked key.
- `load_err` out 1: the last load failed its CRC check.
- `busy` out 1: state is SHIFT, CRC or CHECK.

## Operation

- States: IDLE, SHIFT, CRC, CHECK, ERROR.
- Reset values: state IDLE, `key_out` = 0, `key_valid` = 0, `load_err` = 0, `sdi_ready` = 0, `busy` = 0.
- IDLE, `load_start` = 1: go to SHIFT, clear the shift register, bit counter and CRC register, clear `load_err`, deassert `key_valid`.
- SHIFT: `sdi_ready` = 1.
  - Each accepted bit (`sdi_valid && sdi_ready`) shifts in: shift register shifts left, `sdi` enters at the LSB.
  - Each accepted bit also updates the CRC: `fb = crc[7] ^ sdi`; `crc = {crc[6:0],1'b0} ^ (fb ? 8'h07 : 8'h00)`. Init 0x00, no reflection, no final XOR.
  - After the KEY_W-th accepted bit, go to CRC (macro on) or CHECK (macro off).
- CRC: `sdi_ready` = 1. Accept 8 more bits, MSB first, into the received-CRC register, then go to CHECK. These bits do not update the computed CRC.
- CHECK: `sdi_ready` = 0. One cycle.
  - If the computed CRC equals the received CRC, or the macro is off: `key_out` is loaded from the shift register, `key_valid` goes to 1, state goes to IDLE.
  - On mismatch: state goes to ERROR, `load_err` goes to 1, `key_out` is unchanged, `key_valid` stays 0.
- ERROR: `sdi_ready` = 0. Hold until `load_start`, which behaves as it does in IDLE.
- `load_start` in SHIFT or CRC: restart the load. Counters and the shift register are cleared, and any bit presented in that cycle is discarded. `key_out` keeps the last committed key.
- `sdi_valid` gaps are allowed; the bit counter advances only on accepted bits.
- The bit counter is $clog2(KEY_W)+1 bits wide and never wraps within a load.
- Asserting `rst` at any time forces the reset values immediately. A partial load is lost and `key_out` = 0.

## Timing

- `sdi_ready`, `busy`, `key_out`, `key_valid` and `load_err` are all registered outputs.
- `load_start` sampled at edge E: `sdi_ready` = 1 from E onward (same edge), and the first bit can be accepted at edge E+1.
- Last CRC bit, or last key bit with the macro off, accepted at edge N: state is CHECK after N. `key_out` and `key_valid` (or `load_err`) update at edge N+1.
- Minimum load time with back-to-back bits: KEY_W+8+2 cycles (macro on), KEY_W+2 cycles (macro off), counted from the `load_start` cycle to `key_valid` high.
- While loading, `key_out` is stable and glitch-free, so the locked netlist keeps evaluating with the old key.

## Configuration

- `RLL_KEY_LOADER_CRC_EN` defined: CRC state, CRC-8 computation and comparison are compiled in. `load_err` can assert.
- Not defined: the CRC state and logic are removed. SHIFT goes directly to CHECK, which always commits. `load_err` is tied to 0.

## Structure

- Package `rll_key_loader_pkg` holds:
  - the state enum `key_ld_state_t`;
  - `CRC8_POLY` = 8'h07;
  - `CRC8_INIT` = 8'h00;
  - `KEY_W_DEFAULT` = 32.
- Sub-module `rll_key_crc8`: serial CRC-8 register with clear, enable and bit input, and an 8-bit CRC output. It is instantiated only under the macro.

## Test plan

- Macro on: load key 0xA5A50F0F then CRC 0xD7, back-to-back bits -> `key_out` = 0xA5A50F0F, `key_valid` = 1 at the edge 42 cycles after the `load_start` cycle, `load_err` = 0.
- Macro on: commit 0xA5A50F0F, then load 0x12345678 with CRC 0x00 -> `load_err` = 1, state ERROR, `key_out` stays 0xA5A50F0F, `key_valid` = 0.
- `sdi_valid` toggling every other cycle while loading 0xFFFF0000 with its correct CRC -> commit is identical to the back-to-back case; the bit count ignores idle cycles.
- `load_start` re-pulsed after 10 bits, then a full load of 0x0000FFFF -> `key_out` = 0x0000FFFF; the 10 aborted bits have no effect.
- `rst` asserted mid-SHIFT after a prior commit -> `key_out` = 0, `key_valid` = 0 and `sdi_ready` = 0 asynchronously.
- Macro off: load 0xDEADBEEF -> `key_valid` = 1 after 34 cycles, `load_err` constantly 0.

Source files
------------

// File: rtl/rll_key_loader_pkg.sv
// Shared types and constants for the RLL key loader.
// Contents:
//   key_ld_state_t  - loader FSM state encoding
//   CRC8_POLY       - CRC-8 polynomial x^8 + x^2 + x + 1
//   CRC8_INIT       - CRC-8 initial register value
//   KEY_W_DEFAULT   - default key width (number of keyIn_0_* inputs)
package rll_key_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StCrc,
    StCheck,
    StError
  } key_ld_state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  localparam int unsigned KEY_W_DEFAULT = 32;

endpackage

// File: rtl/rll_key_crc8.sv
// Serial CRC-8 register (poly 0x07, MSB first, no reflection, no final XOR).
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   clr      - synchronous clear back to CRC8_INIT (wins over en)
//   en       - fold bit_in into the CRC this cycle
//   bit_in   - serial data bit
//   crc      - current CRC register value
module rll_key_crc8
  import rll_key_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic fb;
  assign fb = crc[7] ^ bit_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= CRC8_INIT;
    end else if (clr) begin
      crc <= CRC8_INIT;
    end else if (en) begin
      crc <= {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    end
  end

endmodule

// File: rtl/rll_key_loader.sv
// Bit-serial key loader feeding the parallel keyIn_0_* bus of an RLL-locked netlist.
// A key is shifted in MSB first over a valid/ready handshake and is only committed to
// key_out once verified; failed or aborted loads keep the previous key on the bus.
// Optional CRC-8 check of a trailing CRC byte is compiled in with RLL_KEY_LOADER_CRC_EN.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   load_start  - start a new load (also restarts a load in progress)
//   sdi         - serial data bit, MSB first
//   sdi_valid   - sdi holds a valid bit
//   sdi_ready   - loader accepts a bit this cycle (registered)
//   key_out     - committed key, bit i drives keyIn_0_i (registered)
//   key_valid   - key_out holds a committed, checked key (registered)
//   load_err    - last load failed its CRC check (registered, 0 without CRC)
//   busy        - load in progress: SHIFT, CRC or CHECK (registered)
module rll_key_loader
  import rll_key_loader_pkg::*;
#(
  parameter int unsigned KEY_W = KEY_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             sdi,
  input  logic             sdi_valid,
  output logic             sdi_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             load_err,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(KEY_W) + 1;
  localparam logic [CntW-1:0] LastBit = CntW'(KEY_W - 1);

  key_ld_state_t    state_q;
  logic [KEY_W-1:0] shift_q;
  logic [CntW-1:0]  cnt_q;
  logic             accept;

  // sdi_ready is itself a register, so it is high exactly in SHIFT and CRC.
  assign accept = sdi_valid && sdi_ready;

`ifdef RLL_KEY_LOADER_CRC_EN
  logic [7:0] rx_crc_q;
  logic [2:0] crc_cnt_q;
  logic [7:0] crc_calc;
  logic       crc_clr;
  logic       crc_en;

  // Every load_start that (re)starts a load clears the computed CRC.
  assign crc_clr = load_start && (state_q != StCheck);
  assign crc_en  = accept && !load_start && (state_q == StShift);

  rll_key_crc8 u_crc8 (
    .clk    (clk),
    .rst    (rst),
    .clr    (crc_clr),
    .en     (crc_en),
    .bit_in (sdi),
    .crc    (crc_calc)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      cnt_q     <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
      load_err  <= 1'b0;
      sdi_ready <= 1'b0;
      busy      <= 1'b0;
`ifdef RLL_KEY_LOADER_CRC_EN
      rx_crc_q  <= '0;
      crc_cnt_q <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StError: begin
          if (load_start) begin
            state_q   <= StShift;
            shift_q   <= '0;
            cnt_q     <= '0;
            load_err  <= 1'b0;
            key_valid <= 1'b0;
            sdi_ready <= 1'b1;
            busy      <= 1'b1;
`ifdef RLL_KEY_LOADER_CRC_EN
            rx_crc_q  <= '0;
            crc_cnt_q <= '0;
`endif
          end
        end

        StShift: begin
          if (load_start) begin
            // Restart: the bit presented alongside load_start is dropped.
            shift_q <= '0;
            cnt_q   <= '0;
          end else if (accept) begin
            shift_q <= {shift_q[KEY_W-2:0], sdi};
            if (cnt_q == LastBit) begin
`ifdef RLL_KEY_LOADER_CRC_EN
              state_q   <= StCrc;
              crc_cnt_q <= '0;
`else
              state_q   <= StCheck;
              sdi_ready <= 1'b0;
`endif
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end

`ifdef RLL_KEY_LOADER_CRC_EN
        StCrc: begin
          if (load_start) begin
            state_q   <= StShift;
            shift_q   <= '0;
            cnt_q     <= '0;
            rx_crc_q  <= '0;
            crc_cnt_q <= '0;
          end else if (accept) begin
            rx_crc_q <= {rx_crc_q[6:0], sdi};
            if (crc_cnt_q == 3'd7) begin
              state_q   <= StCheck;
              sdi_ready <= 1'b0;
            end else begin
              crc_cnt_q <= crc_cnt_q + 3'd1;
            end
          end
        end
`endif

        StCheck: begin
          busy <= 1'b0;
`ifdef RLL_KEY_LOADER_CRC_EN
          if (crc_calc == rx_crc_q) begin
            key_out   <= shift_q;
            key_valid <= 1'b1;
            state_q   <= StIdle;
          end else begin
            load_err  <= 1'b1;
            state_q   <= StError;
          end
`else
          key_out   <= shift_q;
          key_valid <= 1'b1;
          state_q   <= StIdle;
`endif
        end

        default: begin
          state_q   <= StIdle;
          sdi_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rll_key_loader.sv
module tb_rll_key_loader;

  localparam int KW = 32;
`ifdef RLL_KEY_LOADER_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          load_start;
  logic          sdi;
  logic          sdi_valid;
  logic          sdi_ready;
  logic [KW-1:0] key_out;
  logic          key_valid;
  logic          load_err;
  logic          busy;

  int checks;
  int failures;

  // Reference model of the externally visible committed state.
  logic [KW-1:0] m_key;
  logic          m_valid;
  logic          m_err;

  rll_key_loader #(.KEY_W(KW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .sdi        (sdi),
    .sdi_valid  (sdi_valid),
    .sdi_ready  (sdi_ready),
    .key_out    (key_out),
    .key_valid  (key_valid),
    .load_err   (load_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // CRC-8 as polynomial remainder of key * x^8 modulo x^8 + x^2 + x + 1.
  function automatic logic [7:0] crc8_of(input logic [KW-1:0] k);
    logic [KW+7:0] r;
    r = {k, 8'h00};
    for (int i = KW + 7; i >= 8; i--) begin
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    end
    return r[7:0];
  endfunction

  task automatic chk(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // gap_mode: 0 back-to-back, 1 one idle cycle before every bit, 2 random idles.
  // abort_bits > 0: start a load, feed that many random bits, then restart.
  task automatic do_load(input logic [KW-1:0] key, input logic [7:0] crc, input int gap_mode,
                         input int abort_bits);
    logic [KW+7:0] bits;
    int            nbits;
    int            cyc;
    int            g;
    logic          ok;
    bits  = {key, crc};
    nbits = CRC_ON ? KW + 8 : KW;
    if (abort_bits > 0) begin
      load_start = 1'b1; sdi_valid = 1'b0; tick(); load_start = 1'b0;
      for (int i = 0; i < abort_bits; i++) begin
        sdi_valid = 1'b1; sdi = 1'($urandom); tick();
      end
    end
    // A bit presented with load_start must be discarded.
    load_start = 1'b1; sdi_valid = (abort_bits > 0); sdi = 1'b1;
    tick(); cyc = 1;
    load_start = 1'b0;
    chk("start_ready", 32'(sdi_ready), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_valid", 32'(key_valid), 32'd0);
    chk("start_err", 32'(load_err), 32'd0);
    m_valid = 1'b0;
    m_err   = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
      for (int j = 0; j < g; j++) begin
        sdi_valid = 1'b0; sdi = 1'($urandom); tick(); cyc++;
      end
      sdi_valid = 1'b1; sdi = bits[KW+7-i];
      tick(); cyc++;
      if (key_out !== m_key) begin
        checks++; failures++;
        $display("FAIL key_stable: got %h expected %h", key_out, m_key);
      end
    end
    sdi_valid = 1'b0;
    chk("check_ready", 32'(sdi_ready), 32'd0);
    chk("check_busy", 32'(busy), 32'd1);
    chk("check_valid", 32'(key_valid), 32'd0);
    tick(); cyc++;
    ok = !CRC_ON || (crc == crc8_of(key));
    if (ok) begin
      m_key = key; m_valid = 1'b1; m_err = 1'b0;
    end else begin
      m_valid = 1'b0; m_err = 1'b1;
    end
    chk("done_key", key_out, m_key);
    chk("done_valid", 32'(key_valid), 32'(m_valid));
    chk("done_err", 32'(load_err), 32'(m_err));
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_ready", 32'(sdi_ready), 32'd0);
    if (gap_mode == 0) chk("latency", 32'(cyc), 32'(nbits + 2));
  endtask

  task automatic test_reset();
    chk("rst_key", key_out, '0);
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    chk("rst_ready", 32'(sdi_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
  endtask

  task automatic test_basic();
    do_load(32'hA5A50F0F, crc8_of(32'hA5A50F0F), 0, 0);
  endtask

  task automatic test_bad_crc();
    do_load(32'hA5A50F0F, crc8_of(32'hA5A50F0F), 0, 0);
    do_load(32'h12345678, 8'h00, 0, 0);
    // ERROR holds with the handshake closed until the next load_start.
    repeat (3) tick();
    chk("hold_ready", 32'(sdi_ready), 32'd0);
    chk("hold_err", 32'(load_err), 32'(m_err));
    chk("hold_key", key_out, m_key);
  endtask

  task automatic test_gaps();
    do_load(32'hFFFF0000, crc8_of(32'hFFFF0000), 1, 0);
  endtask

  task automatic test_abort();
    do_load(32'h0000FFFF, crc8_of(32'h0000FFFF), 0, 10);
  endtask

  task automatic test_reset_mid();
    do_load(32'hC0FFEE11, crc8_of(32'hC0FFEE11), 0, 0);
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sdi_valid = 1'b1; sdi = 1'($urandom); tick();
    end
    sdi_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_key", key_out, '0);
    chk("arst_valid", 32'(key_valid), 32'd0);
    chk("arst_ready", 32'(sdi_ready), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    m_key = '0; m_valid = 1'b0; m_err = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    do_load(32'h5A5A1234, crc8_of(32'h5A5A1234), 0, 0);
  endtask

  task automatic test_random();
    logic [KW-1:0] k;
    logic [7:0]    c;
    for (int n = 0; n < 8; n++) begin
      k = KW'($urandom);
      c = crc8_of(k);
      if ($urandom_range(0, 2) == 0) c = c ^ 8'(1 << $urandom_range(0, 7));
      do_load(k, c, 2, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    m_key = '0; m_valid = 1'b0; m_err = 1'b0;
    rst = 1'b1; load_start = 1'b0; sdi = 1'b0; sdi_valid = 1'b0;
    repeat (2) tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_bad_crc();
    test_gaps();
    test_abort();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
